tm1638_display_driver: RTL

//  Drives a TM1638 LED/7-seg board: encodes N_DIGITS 4-bit values to segments, serialises the

---
 rtl/tm1638_display_driver.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/tm1638_display_driver.sv
// TM1638 board driver: encodes digits/dp/LEDs and serialises the three-frame write sequence on STB/CLK/DIO.
// Latency: first STB fall 2 cycles after start_i is accepted; done_o comes 314*CLK_DIV cycles after that fall.
// Handshake only: start_i is sampled in IDLE, requests while busy_o is high are dropped, and the TM side has no stall.
module tm1638_display_driver #(
  parameter int CLK_DIV  = 2,
  parameter int N_DIGITS = 8,
  parameter int HEX_EN   = 1,
  parameter int LZ_BLANK = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic [7:0]            leds_i,
  input  logic [2:0]            bright_i,
  input  logic                  disp_on_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  tm_stb_o,
  output logic                  tm_clk_o,
  output logic                  tm_dio_o
);

  localparam int DW = $clog2(2 * CLK_DIV) + 1;
  localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_LAST  = DW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CMD1, S_GAP, S_ADDR, S_DATA, S_CMD3, S_DONE
  } state_t;

  // SETUP: STB low with CLK high before the first bit; HOLD: CLK high after the last bit.
  typedef enum logic [1:0] {PH_SETUP, PH_LOW, PH_HIGH, PH_HOLD} phase_t;

  state_t                state;
  phase_t                phase;
  logic [DW-1:0]         div;
  logic [2:0]            bit_cnt;
  logic [3:0]            byte_cnt;
  logic [7:0]            shreg;
  logic                  gap_to_cmd3;

  // Shadow copies of the inputs, frozen for the whole update.
  logic [4*N_DIGITS-1:0] dig_s;
  logic [N_DIGITS-1:0]   dp_s;
  logic [7:0]            leds_s;
  logic [2:0]            bright_s;
  logic                  on_s;

  // Address-ordered payload of the F2 frame.
  logic [7:0]            data_q [16];

  logic [31:0]           dig_pad;
  logic [7:0]            dp_pad;
  logic [7:0]            seg_c [8];
  logic [3:0]            nidx;
  logic [7:0]            next_byte;

  assign dig_pad   = 32'(dig_s);
  assign dp_pad    = 8'(dp_s);
  assign nidx      = (state == S_ADDR) ? 4'd0 : byte_cnt + 4'd1;
  assign next_byte = data_q[nidx];

  function automatic logic [7:0] glyph(input logic [3:0] code);
    glyph = 8'h80;
    case (code)
      4'h0: glyph = 8'h3F;
      4'h1: glyph = 8'h06;
      4'h2: glyph = 8'h5B;
      4'h3: glyph = 8'h4F;
      4'h4: glyph = 8'h66;
      4'h5: glyph = 8'h6D;
      4'h6: glyph = 8'h7D;
      4'h7: glyph = 8'h07;
      4'h8: glyph = 8'h7F;
      4'h9: glyph = 8'h6F;
      4'hA: glyph = (HEX_EN != 0) ? 8'h77 : 8'h80;
      4'hB: glyph = (HEX_EN != 0) ? 8'h7C : 8'h80;
      4'hC: glyph = (HEX_EN != 0) ? 8'h39 : 8'h80;
      4'hD: glyph = (HEX_EN != 0) ? 8'h5E : 8'h80;
      4'hE: glyph = (HEX_EN != 0) ? 8'h79 : 8'h80;
      4'hF: glyph = (HEX_EN != 0) ? 8'h71 : 8'h80;
      default: glyph = 8'h80;
    endcase
  endfunction

  // Segment encode from the shadow digits, scanning from the highest digit down so a run of leading zeros can be blanked.
  always_comb begin
    logic lead;
    lead = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      seg_c[k] = 8'h00;
      if (k < N_DIGITS) begin
        if ((LZ_BLANK != 0) && lead && (k != 0) && (dig_pad[4*k +: 4] == 4'h0)) begin
          seg_c[k] = {dp_pad[k], 7'b0};
        end else begin
          lead     = 1'b0;
          seg_c[k] = glyph(dig_pad[4*k +: 4]) | {dp_pad[k], 7'b0};
        end
      end
    end
  end

  // Sequencer: capture, encode, then shift F1 / F2 / F3 out LSB first with registered pin outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      phase       <= PH_SETUP;
      div         <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      shreg       <= '0;
      gap_to_cmd3 <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      tm_stb_o    <= 1'b1;
      tm_clk_o    <= 1'b1;
      tm_dio_o    <= 1'b1;
      dig_s       <= '0;
      dp_s        <= '0;
      leds_s      <= '0;
      bright_s    <= '0;
      on_s        <= 1'b0;
      for (int k = 0; k < 16; k++) data_q[k] <= 8'h00;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          busy_o <= 1'b0;
          if (start_i) begin
            dig_s    <= digits_i;
            dp_s     <= dp_i;
            leds_s   <= leds_i;
            bright_s <= bright_i;
            on_s     <= disp_on_i;
            busy_o   <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          for (int k = 0; k < 8; k++) begin
            data_q[2*k]   <= seg_c[k];
            data_q[2*k+1] <= {7'b0, leds_s[k]};
          end
          tm_stb_o <= 1'b0;
          shreg    <= 8'h40;
          phase    <= PH_SETUP;
          div      <= '0;
          bit_cnt  <= '0;
          state    <= S_CMD1;
        end
        S_GAP: begin
          if (div == GAP_LAST) begin
            div      <= '0;
            tm_stb_o <= 1'b0;
            phase    <= PH_SETUP;
            bit_cnt  <= '0;
            if (gap_to_cmd3) begin
              shreg <= {4'b1000, on_s, bright_s};
              state <= S_CMD3;
            end else begin
              shreg <= 8'hC0;
              state <= S_ADDR;
            end
          end else begin
            div <= div + DW'(1);
          end
        end
        S_DONE: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          // Byte-shifting states: CMD1, ADDR, DATA, CMD3.
          if (div != HALF_LAST) begin
            div <= div + DW'(1);
          end else begin
            div <= '0;
            case (phase)
              PH_SETUP: begin
                phase    <= PH_LOW;
                tm_clk_o <= 1'b0;
                tm_dio_o <= shreg[0];
                shreg    <= {1'b0, shreg[7:1]};
              end
              PH_LOW: begin
                phase    <= PH_HIGH;
                tm_clk_o <= 1'b1;
              end
              PH_HIGH: begin
                if (bit_cnt != 3'd7) begin
                  bit_cnt  <= bit_cnt + 3'd1;
                  phase    <= PH_LOW;
                  tm_clk_o <= 1'b0;
                  tm_dio_o <= shreg[0];
                  shreg    <= {1'b0, shreg[7:1]};
                end else if ((state == S_ADDR) || ((state == S_DATA) && (byte_cnt != 4'd15))) begin
                  // F2 runs its 17 bytes back to back with no STB release.
                  bit_cnt  <= '0;
                  phase    <= PH_LOW;
                  tm_clk_o <= 1'b0;
                  tm_dio_o <= next_byte[0];
                  shreg    <= {1'b0, next_byte[7:1]};
                  byte_cnt <= nidx;
                  state    <= S_DATA;
                end else begin
                  phase <= PH_HOLD;
                end
              end
              default: begin
                tm_stb_o <= 1'b1;
                tm_dio_o <= 1'b1;
                if (state == S_CMD3) begin
                  done_o <= 1'b1;
                  state  <= S_DONE;
                end else begin
                  gap_to_cmd3 <= (state == S_DATA);
                  state       <= S_GAP;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
